// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and sizing helpers for the parameterised data memory.
//   dmem_state_e : access controller states
//   BYTE_W       : bits per byte lane
//   WAIT_CNT_W   : width of the wait-state down-counter (0..15 wait states)
//   lane_count() : number of byte lanes in a DATA_W word
//   boff_width() : number of byte-offset address bits for a DATA_W word
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int boff_width(input int data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word-organised storage with per-byte-lane write enables. Storage is not
// reset. With DMEM_PARITY_EN defined, one even-parity bit is kept per byte
// lane and a per-lane mismatch vector is reported for the addressed word.
// Ports:
//   clk       in   write clock
//   we        in   per-lane write enables
//   idx       in   word index (shared by read and write)
//   wdata     in   write data, lane k at bits [8k+7:8k]
//   rdata     out  asynchronous read of the addressed word
//   perr_lane out  per-lane parity mismatch (DMEM_PARITY_EN builds only)
// ---------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int DEPTH_WORDS = 256,
  localparam int LANES       = lane_count(DATA_W),
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
`ifdef DMEM_PARITY_EN
  ,
  output logic [LANES-1:0]  perr_lane
`endif
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[idx][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
    end
  end

  assign rdata = mem[idx];

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH_WORDS];

  // Even parity: stored bit equals XOR of the lane, so lane ^ bit == 0.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) par_mem[idx][l] <= ^wdata[l*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    perr_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      perr_lane[l] = (^rdata[l*BYTE_W +: BYTE_W]) ^ par_mem[idx][l];
    end
  end
`endif

endmodule

// File: rtl/param_data_memory.sv
// ---------------------------------------------------------------------------
// param_data_memory
// Single-port data memory with a request/ready handshake, programmable wait
// states, byte and word access, sign-extending byte loads and misalignment
// detection. Optional per-byte parity is enabled with `define DMEM_PARITY_EN.
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   request strobe, only looked at in IDLE
//   memoryWrite  in   store request
//   memoryRead   in   load request (dropped if memoryWrite is also set)
//   sb           in   1 = byte access, 0 = full word
//   signedLoad   in   sign-extend byte loads
//   address      in   byte address (upper bits wrap)
//   dataWrite    in   store data, byte stores use [7:0]
//   dataRead     out  last completed load result
//   ready        out  one-cycle completion pulse
//   busy         out  access in flight
//   misaligned   out  word access with nonzero byte offset, with ready
//   parityErr    out  parity mismatch on a load, with ready
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for req with a read or write qualifier
// ST_WAIT | wait-state down-counter running; commit on terminal count
// ST_DONE | ready pulse, status flags valid
// ---------------------------------------------------------------------------
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              memoryWrite,
  input  logic              memoryRead,
  input  logic              sb,
  input  logic              signedLoad,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataWrite,
  output logic [DATA_W-1:0] dataRead,
  output logic              ready,
  output logic              busy,
  output logic              misaligned,
  output logic              parityErr
);

  localparam int LANES  = lane_count(DATA_W);
  localparam int BOFF_W = boff_width(DATA_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int AW     = BOFF_W + IDX_W;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_e state, state_nxt;

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [AW-1:0]         addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  sb_q, sl_q, wr_q, rd_q;

  logic                  accept, wait_tc, mis;
  logic [BOFF_W-1:0]     lane;
  logic [IDX_W-1:0]      idx;
  logic [LANES-1:0]      we;
  logic [DATA_W-1:0]     arr_wdata, arr_rdata, ld_val;
  logic [BYTE_W-1:0]     byte_sel;

  // Address bits above the memory span are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^address[ADDR_W-1:AW];

  assign accept  = (state == ST_IDLE) && req && (memoryRead || memoryWrite);
  assign wait_tc = (state == ST_WAIT) && (wait_cnt == '0);
  assign lane    = addr_q[BOFF_W-1:0];
  assign idx     = addr_q[BOFF_W +: IDX_W];
  assign mis     = !sb_q && (lane != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)  state_nxt = ST_WAIT;
      ST_WAIT: if (wait_tc) state_nxt = ST_DONE;
      ST_DONE:              state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Loaded with WAIT_CYCLES on accept; WAIT exits on terminal count, so the
  // state lasts WAIT_CYCLES+1 cycles and ready lands WAIT_CYCLES+1 after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= WAIT_LD;
    end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sb_q    <= 1'b0;
      sl_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= address[AW-1:0];
      wdata_q <= dataWrite;
      sb_q    <= sb;
      sl_q    <= signedLoad;
      wr_q    <= memoryWrite;
      rd_q    <= memoryRead && !memoryWrite;  // write wins when both are set
    end
  end

  always_comb begin
    we        = '0;
    arr_wdata = wdata_q;
    if (wait_tc && wr_q && !mis) begin
      if (sb_q) begin
        we[lane]  = 1'b1;
        arr_wdata = {LANES{wdata_q[BYTE_W-1:0]}};
      end else begin
        we = '1;
      end
    end
  end

  assign byte_sel = arr_rdata[int'(lane)*BYTE_W +: BYTE_W];
  assign ld_val   = sb_q ? {{(DATA_W-BYTE_W){sl_q & byte_sel[BYTE_W-1]}}, byte_sel}
                         : arr_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     dataRead <= '0;
    else if (wait_tc && rd_q && !mis) dataRead <= ld_val;
  end

  assign ready      = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign misaligned = ready && mis;

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] perr_lane;
  logic             perr_hit, perr_q;

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .we        (we),
    .idx       (idx),
    .wdata     (arr_wdata),
    .rdata     (arr_rdata),
    .perr_lane (perr_lane)
  );

  // Only the lanes actually returned by the load are checked.
  assign perr_hit = sb_q ? perr_lane[lane] : |perr_lane;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     perr_q <= 1'b0;
    else if (wait_tc) perr_q <= rd_q && !mis && perr_hit;
  end

  assign parityErr = ready && perr_q;
`else
  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_param_data_memory.sv
module tb_param_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: WAIT_CYCLES=1, dut_b: WAIT_CYCLES=3
  logic        a_rst, a_req, a_wr, a_rd, a_sb, a_sl;
  logic [15:0] a_addr, a_wd, a_dr;
  logic        a_rdy, a_busy, a_mis, a_perr;
  logic        b_rst, b_req, b_wr, b_rd, b_sb, b_sl;
  logic [15:0] b_addr, b_wd, b_dr;
  logic        b_rdy, b_busy, b_mis, b_perr;

  int checks = 0;
  int errors = 0;

  param_data_memory #(.DATA_W(16), .DEPTH_WORDS(256), .ADDR_W(16), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(a_rst), .req(a_req), .memoryWrite(a_wr), .memoryRead(a_rd),
    .sb(a_sb), .signedLoad(a_sl), .address(a_addr), .dataWrite(a_wd),
    .dataRead(a_dr), .ready(a_rdy), .busy(a_busy), .misaligned(a_mis), .parityErr(a_perr));

  param_data_memory #(.DATA_W(16), .DEPTH_WORDS(256), .ADDR_W(16), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(b_rst), .req(b_req), .memoryWrite(b_wr), .memoryRead(b_rd),
    .sb(b_sb), .signedLoad(b_sl), .address(b_addr), .dataWrite(b_wd),
    .dataRead(b_dr), .ready(b_rdy), .busy(b_busy), .misaligned(b_mis), .parityErr(b_perr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rq, input bit wr, input bit rd, input bit s,
                       input bit sl, input logic [15:0] ad, input logic [15:0] wd);
    if (sel) begin
      b_req = rq; b_wr = wr; b_rd = rd; b_sb = s; b_sl = sl; b_addr = ad; b_wd = wd;
    end else begin
      a_req = rq; a_wr = wr; a_rd = rd; a_sb = s; a_sl = sl; a_addr = ad; a_wd = wd;
    end
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? b_rdy : a_rdy;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // One complete access. poke=1 keeps req asserted (as a write to 0x0010)
  // for the whole time the access is in flight.
  task automatic access(input bit sel, input bit wr, input bit rd, input bit s, input bit sl,
                        input logic [15:0] ad, input logic [15:0] wd, input bit poke,
                        input string tag, output logic [15:0] dr, output logic mis,
                        output logic perr);
    int lat;
    @(negedge clk);
    drive(sel, 1'b1, wr, rd, s, sl, ad, wd);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy_of(sel)}, 32'd1);
    if (poke) drive(sel, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hDEAD);
    else      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    lat = 0;
    while (!rdy_of(sel) && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, sel ? 32'd4 : 32'd2);
    dr   = sel ? b_dr  : a_dr;
    mis  = sel ? b_mis : a_mis;
    perr = sel ? b_perr : a_perr;
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, rdy_of(sel), busy_of(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [15:0] dr;
    logic        mis, perr;

    a_rst = 1'b0; b_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_dr",   {16'd0, a_dr}, 32'd0);
    chk("rst_flag", {28'd0, a_rdy, a_busy, a_mis, a_perr}, 32'd0);
    a_rst = 1'b1; b_rst = 1'b1;

    // word write / read
    access(0, 1, 0, 0, 0, 16'h0010, 16'h1234, 0, "wr1234", dr, mis, perr);
    chk("wr1234_mis", {31'd0, mis}, 32'd0);
    access(0, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, "rd1234", dr, mis, perr);
    chk("rd1234_dr", {16'd0, dr}, 32'h1234);
    chk("rd1234_perr", {31'd0, perr}, 32'd0);

    // byte store into lane 1, then word and byte loads
    access(0, 1, 0, 1, 0, 16'h0011, 16'h77AB, 0, "wrbyte", dr, mis, perr);
    access(0, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, "rdAB34", dr, mis, perr);
    chk("rdAB34_dr", {16'd0, dr}, 32'hAB34);
    access(0, 0, 1, 1, 1, 16'h0011, 16'h0000, 0, "rdsx", dr, mis, perr);
    chk("rdsx_dr", {16'd0, dr}, 32'hFFAB);
    access(0, 0, 1, 1, 0, 16'h0011, 16'h0000, 0, "rdzx", dr, mis, perr);
    chk("rdzx_dr", {16'd0, dr}, 32'h00AB);
    access(0, 0, 1, 1, 1, 16'h0010, 16'h0000, 0, "rdsxpos", dr, mis, perr);
    chk("rdsxpos_dr", {16'd0, dr}, 32'h0034);

    // address wrap: 0xFFFA and 0x01FA both hit word 0xFD
    access(0, 1, 0, 0, 0, 16'hFFFA, 16'h0045, 0, "wrwrap", dr, mis, perr);
    access(0, 0, 1, 0, 0, 16'h01FA, 16'h0000, 0, "rdwrap", dr, mis, perr);
    chk("rdwrap_dr", {16'd0, dr}, 32'h0045);

    // misaligned word read with req held high while busy
    access(0, 0, 1, 0, 0, 16'h0013, 16'h0000, 1, "rdmis", dr, mis, perr);
    chk("rdmis_flag", {31'd0, mis}, 32'd1);
    chk("rdmis_dr", {16'd0, dr}, 32'h0045);
    // misaligned word write must not change memory
    access(0, 1, 0, 0, 0, 16'h0011, 16'hBEEF, 0, "wrmis", dr, mis, perr);
    chk("wrmis_flag", {31'd0, mis}, 32'd1);
    access(0, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, "rdkeep", dr, mis, perr);
    chk("rdkeep_dr", {16'd0, dr}, 32'hAB34);

    // read+write together: write only, dataRead held
    access(0, 1, 1, 0, 0, 16'h0010, 16'h9999, 0, "rdwr", dr, mis, perr);
    chk("rdwr_dr", {16'd0, dr}, 32'hAB34);
    access(0, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, "rd9999", dr, mis, perr);
    chk("rd9999_dr", {16'd0, dr}, 32'h9999);

`ifdef DMEM_PARITY_EN
    access(0, 1, 0, 0, 0, 16'h0030, 16'h00FF, 0, "pwr", dr, mis, perr);
    access(0, 0, 1, 0, 0, 16'h0030, 16'h0000, 0, "prd", dr, mis, perr);
    chk("prd_dr", {16'd0, dr}, 32'h00FF);
    chk("prd_perr", {31'd0, perr}, 32'd0);
    dut_a.u_array.par_mem[24][0] = ~dut_a.u_array.par_mem[24][0];
    access(0, 0, 1, 0, 0, 16'h0030, 16'h0000, 0, "pbad", dr, mis, perr);
    chk("pbad_perr", {31'd0, perr}, 32'd1);
    chk("pbad_dr", {16'd0, dr}, 32'h00FF);
    access(0, 0, 1, 1, 0, 16'h0031, 16'h0000, 0, "plane1", dr, mis, perr);
    chk("plane1_perr", {31'd0, perr}, 32'd0);
`endif

    // WAIT_CYCLES=3 instance: reset aborts an in-flight write
    access(1, 1, 0, 0, 0, 16'h0020, 16'h1111, 0, "b_wr1111", dr, mis, perr);
    access(1, 0, 1, 0, 0, 16'h0020, 16'h0000, 0, "b_rd1111", dr, mis, perr);
    chk("b_rd1111_dr", {16'd0, dr}, 32'h1111);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h5555);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("b_abort_busy", {31'd0, b_busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    #1;
    chk("b_abort_dr", {16'd0, b_dr}, 32'd0);
    chk("b_abort_flag", {28'd0, b_rdy, b_busy, b_mis, b_perr}, 32'd0);
    repeat (3) @(negedge clk);
    b_rst = 1'b1;
    access(1, 0, 1, 0, 0, 16'h0020, 16'h0000, 0, "b_rdafter", dr, mis, perr);
    chk("b_rdafter_dr", {16'd0, dr}, 32'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width in bits (16 or 32).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, storage depth in DATA_W words (power of two).
REQ-003 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, extra access wait states (0..15).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  1  request strobe, sampled only in IDLE.
REQ-008 SHALL have port memoryWrite  input  1  write request qualifier.
REQ-009 SHALL have port memoryRead  input  1  read request qualifier.
REQ-010 SHALL have port sb  input  1  byte access (1) or full-word access (0).
REQ-011 SHALL have port signedLoad  input  1  sign-extend byte loads.
REQ-012 SHALL have port address  input  ADDR_W  byte address.
REQ-013 SHALL have port dataWrite  input  DATA_W  store data; byte stores use bits [7:0].
REQ-014 SHALL have port dataRead  output  DATA_W  load result, held until the next completed read.
REQ-015 SHALL have ports ready (output, 1, one-cycle completion pulse), busy (output, 1, access in flight), misaligned (output, 1, pulses with ready), and parityErr (output, 1, pulses with ready).

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; busy=1 in WAIT and DONE.
REQ-017 SHALL accept a request on a rising edge in IDLE with req=1 and (memoryRead|memoryWrite)=1, latching address, sb, signedLoad, dataWrite and operation.
REQ-018 SHALL count WAIT_CYCLES cycles in WAIT; with WAIT_CYCLES=0, WAIT lasts one cycle; ready asserts exactly WAIT_CYCLES+1 cycles after acceptance (DONE state).
REQ-019 SHALL ignore req while busy; no queueing.
REQ-020 SHALL, when memoryRead and memoryWrite are both 1, perform the write only; the read is dropped and dataRead is unchanged.
REQ-021 SHALL be little-endian: byte k of a word sits at data bits [8k+7:8k]; word index = address[log2(DEPTH_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; upper address bits ignored (wrap-around).
REQ-022 SHALL, for byte store, modify only the addressed byte lane.
REQ-023 SHALL, for byte load, return the addressed byte zero-extended (signedLoad=0) or sign-extended (signedLoad=1).
REQ-024 SHALL flag full-word access with nonzero low byte-offset bits as misaligned: no memory change, dataRead unchanged, misaligned=1 with ready.
REQ-025 SHALL commit writes on the WAIT->DONE transition only.

Reset
REQ-026 SHALL, on reset_n=0, immediately force state IDLE, dataRead=0, ready=0, busy=0, misaligned=0, parityErr=0, and clear the wait counter.
REQ-027 SHALL NOT reset storage contents; a write aborted by reset before commit SHALL leave memory unchanged.

Configuration
REQ-028 SHALL, with DMEM_PARITY_EN defined, store one even-parity bit per byte, check all addressed lanes on read, and pulse parityErr with ready on mismatch (dataRead still updated).
REQ-029 SHALL, without DMEM_PARITY_EN, omit the parity storage and tie parityErr to 0.

Structure
REQ-030 SHALL take the FSM state typedef, byte-offset width function and lane-count constants from shared package dmem_pkg.
REQ-031 SHALL place storage (byte-lane write enables, optional parity bits) in sub-module dmem_array; control FSM in the top.

Verification (DATA_W=16, DEPTH_WORDS=256, WAIT_CYCLES=1)
REQ-032 SHALL cover: write 0x1234 @0x0010, then read @0x0010 -> ready 2 cycles after each accept, dataRead=0x1234.
REQ-033 SHALL cover: byte write 0xAB @0x0011, then word read @0x0010 -> 0xAB34; byte read @0x0011 with signedLoad=1 -> 0xFFAB, with signedLoad=0 -> 0x00AB.
REQ-034 SHALL cover: word write 0x0045 @0xFFFA, then read @0x01FA -> 0x0045 (wrap).
REQ-035 SHALL cover: word read @0x0013 -> misaligned=1 with ready, dataRead unchanged; req asserted during busy -> ignored.
REQ-036 SHALL cover: WAIT_CYCLES=3, write 0x5555 @0x0020 over prior 0x1111, reset_n low in WAIT -> outputs 0 immediately; later read -> 0x1111.
REQ-037 SHALL cover: with DMEM_PARITY_EN, normal write/read -> parityErr=0; parity bit forced flipped -> parityErr=1 with ready.
